// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch vs. data port, round-robin on ties,
// fixed-length ACCESS phase, unaligned-word data requests fault without touching memory.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_word,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ready,
  output logic        d_fault,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  output logic        mem_we,
  output logic        mem_word,
  output logic        busy
);

  // state  | meaning
  // IDLE   | waiting for a request, arbitration happens here
  // ACCESS | memory cycle in progress, WAIT_CYCLES long
  // DONE   | one-cycle ready pulse to the granted port
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_LD = WAIT_CYCLES[3:0];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        last_d_q;
  logic        gnt_d_q;
  logic        we_q;
  logic        word_q;
  logic        fault_q;
  logic [15:0] addr_q;
  logic [15:0] din_q;
  logic [15:0] if_rdata_q;
  logic [15:0] d_rdata_q;

  logic pick_any, pick_d, unaligned, last_access;

  assign pick_any    = if_req | d_req;
  assign pick_d      = d_req & (~if_req | ~last_d_q);
  assign unaligned   = pick_d & d_word & d_addr[0];
  assign last_access = (state_q == ACCESS) && (cnt_q <= 4'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = unaligned ? DONE : ACCESS;
      ACCESS:  if (last_access) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    if_ready = (state_q == DONE) && !gnt_d_q;
    d_ready  = (state_q == DONE) && gnt_d_q;
    d_fault  = (state_q == DONE) && gnt_d_q && fault_q;
    // write strobe only on the first ACCESS cycle so a store hits memory once
    mem_we   = (state_q == ACCESS) && we_q && (cnt_q == WAIT_LD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      last_d_q   <= 1'b1;
      gnt_d_q    <= 1'b0;
      we_q       <= 1'b0;
      word_q     <= 1'b0;
      fault_q    <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (state_q == IDLE && pick_any) begin
      last_d_q <= pick_d;
      gnt_d_q  <= pick_d;
      cnt_q    <= WAIT_LD;
      fault_q  <= unaligned;
      if (pick_d) begin
        addr_q <= d_addr;
        word_q <= d_word;
        we_q   <= d_we & ~unaligned;
        din_q  <= d_word ? d_wdata : {d_wdata[7:0], d_wdata[7:0]};
      end else begin
        addr_q <= if_addr & 16'hFFFE;
        word_q <= 1'b1;
        we_q   <= 1'b0;
      end
    end else if (state_q == ACCESS) begin
      cnt_q <= cnt_q - 4'd1;
      if (last_access && !we_q) begin
        if (gnt_d_q) d_rdata_q  <= word_q ? mem_dout : {8'h00, mem_dout[7:0]};
        else         if_rdata_q <= mem_dout;
      end
    end
  end

  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign mem_word = word_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one WAIT_CYCLES=1 instance for most scenarios,
// one WAIT_CYCLES=3 instance for the stretched access timing.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_word = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_dout = '0;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_din;
  logic        if_ready, d_ready, d_fault, mem_we, mem_word, busy;

  logic        d3_req = 1'b0, d3_word = 1'b0;
  logic [15:0] d3_addr = '0, mem3_dout = '0;
  logic [15:0] if3_rdata, d3_rdata, mem3_addr, mem3_din;
  logic        if3_ready, d3_ready, d3_fault, mem3_we, mem3_word, busy3;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_word(d_word), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_fault(d_fault),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_we(mem_we), .mem_word(mem_word), .busy(busy)
  );

  mem_arbiter #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req(1'b0), .if_addr(16'h0000), .if_rdata(if3_rdata), .if_ready(if3_ready),
    .d_req(d3_req), .d_we(1'b0), .d_word(d3_word), .d_addr(d3_addr), .d_wdata(16'h0000),
    .d_rdata(d3_rdata), .d_ready(d3_ready), .d_fault(d3_fault),
    .mem_addr(mem3_addr), .mem_din(mem3_din), .mem_dout(mem3_dout),
    .mem_we(mem3_we), .mem_word(mem3_word), .busy(busy3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] all_or;
    #2;
    all_or = mem_addr | mem_din | if_rdata | d_rdata |
             {10'd0, mem_we, mem_word, if_ready, d_ready, d_fault, busy};
    n_total++;
    if (all_or !== 16'h0000) $display("FAIL reset_outputs got=%h exp=0000", all_or);
    else n_pass++;
    n_total++;
    if (busy3 !== 1'b0) $display("FAIL reset_busy3 got=%b exp=0", busy3);
    else n_pass++;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_fetch();
    mem_dout = 16'h6194;
    if_addr  = 16'h0005;
    if_req   = 1'b1;
    tick();
    n_total++;
    if ({busy, mem_word, mem_we, if_ready, mem_addr} !== {4'b1100, 16'h0004})
      $display("FAIL fetch_access got=%b%b%b%b addr=%h exp=1100 addr=0004",
               busy, mem_word, mem_we, if_ready, mem_addr);
    else n_pass++;
    tick();
    n_total++;
    if ({if_ready, d_ready, if_rdata} !== {2'b10, 16'h6194})
      $display("FAIL fetch_ready got=%b%b rdata=%h exp=10 rdata=6194", if_ready, d_ready, if_rdata);
    else n_pass++;
    if_req = 1'b0;
    tick();
    n_total++;
    if ({if_ready, busy, if_rdata} !== {2'b00, 16'h6194})
      $display("FAIL fetch_after got=%b%b rdata=%h exp=00 rdata=6194", if_ready, busy, if_rdata);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    string seq;
    int overlap;
    reset = 1'b0;
    tick();
    n_total++;
    if ({busy, mem_addr} !== 17'h0) $display("FAIL rr_reset got=%b %h exp=0 0000", busy, mem_addr);
    else n_pass++;
    reset   = 1'b1;
    seq     = "";
    overlap = 0;
    if_addr = 16'h0100;
    d_addr  = 16'h0010; d_we = 1'b0; d_word = 1'b1;
    if_req  = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (if_ready && d_ready) overlap++;
      if (if_ready) seq = {seq, "F"};
      if (d_ready)  seq = {seq, "D"};
      if (seq.len() >= 4) break;
    end
    if_req = 1'b0; d_req = 1'b0;
    n_total++;
    if (seq != "FDFD") $display("FAIL rr_order got=%s exp=FDFD", seq);
    else n_pass++;
    n_total++;
    if (overlap !== 0) $display("FAIL rr_overlap got=%0d exp=0", overlap);
    else n_pass++;
    tick();
    tick();
  endtask

  task automatic test_word_load();
    logic got;
    logic fault;
    got = 1'b0; fault = 1'b0;
    mem_dout = 16'hBEEF;
    d_addr = 16'h0040; d_we = 1'b0; d_word = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (d_ready) begin
        got = 1'b1; fault = d_fault; d_req = 1'b0;
        break;
      end
    end
    n_total++;
    if ({got, fault, d_rdata} !== {2'b10, 16'hBEEF})
      $display("FAIL word_load got=%b%b rdata=%h exp=10 rdata=beef", got, fault, d_rdata);
    else n_pass++;
    n_total++;
    if ({mem_word, mem_addr} !== {1'b1, 16'h0040})
      $display("FAIL word_load_addr got=%b %h exp=1 0040", mem_word, mem_addr);
    else n_pass++;
    tick();
  endtask

  task automatic test_byte_store();
    int we_n, rdy_n, fault_n;
    logic [15:0] din_s, addr_s;
    logic word_s;
    we_n = 0; rdy_n = 0; fault_n = 0;
    din_s = '0; addr_s = '0; word_s = 1'b1;
    d_addr = 16'h0031; d_wdata = 16'h12AB; d_we = 1'b1; d_word = 1'b0; d_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_we) begin
        we_n++; din_s = mem_din; addr_s = mem_addr; word_s = mem_word;
      end
      if (d_ready) begin
        rdy_n++; d_req = 1'b0;
        if (d_fault) fault_n++;
      end
    end
    n_total++;
    if ({din_s, addr_s, word_s} !== {16'hABAB, 16'h0031, 1'b0})
      $display("FAIL byte_store_bus got din=%h addr=%h word=%b exp din=abab addr=0031 word=0",
               din_s, addr_s, word_s);
    else n_pass++;
    n_total++;
    if (we_n != 1 || rdy_n != 1 || fault_n != 0)
      $display("FAIL byte_store_pulses got we=%0d rdy=%0d fault=%0d exp we=1 rdy=1 fault=0",
               we_n, rdy_n, fault_n);
    else n_pass++;
  endtask

  task automatic test_unaligned();
    int busy_n, rdy_n, fault_n, we_n;
    busy_n = 0; rdy_n = 0; fault_n = 0; we_n = 0;
    d_addr = 16'h0029; d_we = 1'b0; d_word = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy) busy_n++;
      if (mem_we) we_n++;
      if (d_fault) fault_n++;
      if (d_ready) begin
        rdy_n++; d_req = 1'b0;
      end
    end
    n_total++;
    if (busy_n != 1 || rdy_n != 1 || fault_n != 1 || we_n != 0)
      $display("FAIL unaligned_pulses got busy=%0d rdy=%0d fault=%0d we=%0d exp 1 1 1 0",
               busy_n, rdy_n, fault_n, we_n);
    else n_pass++;
    n_total++;
    if (d_rdata !== 16'hBEEF) $display("FAIL unaligned_rdata got=%h exp=beef", d_rdata);
    else n_pass++;
  endtask

  task automatic test_wait3();
    int rdy_at, busy_n;
    for (int pass = 0; pass < 2; pass++) begin
      rdy_at = -1; busy_n = 0;
      mem3_dout = 16'hF0F0;
      d3_addr = 16'h0028; d3_word = (pass == 0); d3_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (busy3) busy_n++;
        if (d3_ready && rdy_at < 0) begin
          rdy_at = i; d3_req = 1'b0;
        end
      end
      n_total++;
      if (rdy_at != 3 || busy_n != 4)
        $display("FAIL wait3_timing pass=%0d got rdy_at=%0d busy=%0d exp rdy_at=3 busy=4",
                 pass, rdy_at, busy_n);
      else n_pass++;
      n_total++;
      if (d3_rdata !== ((pass == 0) ? 16'hF0F0 : 16'h00F0))
        $display("FAIL wait3_rdata pass=%0d got=%h exp=%h", pass, d3_rdata,
                 (pass == 0) ? 16'hF0F0 : 16'h00F0);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_store();
    int rdy_n;
    logic got;
    rdy_n = 0; got = 1'b0;
    d_addr = 16'h0050; d_wdata = 16'h5A5A; d_we = 1'b1; d_word = 1'b1; d_req = 1'b1;
    tick();
    reset = 1'b0;
    d_req = 1'b0;
    #1;
    n_total++;
    if ({mem_we, busy, d_ready, mem_word, mem_addr, mem_din} !== 36'h0)
      $display("FAIL midreset_outputs got we=%b busy=%b rdy=%b word=%b addr=%h din=%h exp all 0",
               mem_we, busy, d_ready, mem_word, mem_addr, mem_din);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (d_ready || mem_we) rdy_n++;
    end
    reset = 1'b1;
    mem_dout = 16'h1357; if_addr = 16'h0011; if_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (d_ready || mem_we) rdy_n++;
      if (if_ready) begin
        got = 1'b1; if_req = 1'b0;
        break;
      end
    end
    n_total++;
    if (rdy_n != 0) $display("FAIL midreset_no_pulse got=%0d exp=0", rdy_n);
    else n_pass++;
    n_total++;
    if ({got, if_rdata, mem_addr} !== {1'b1, 16'h1357, 16'h0010})
      $display("FAIL midreset_resume got=%b rdata=%h addr=%h exp=1 rdata=1357 addr=0010",
               got, if_rdata, mem_addr);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_round_robin();
    test_word_load();
    test_byte_store();
    test_unaligned();
    test_wait3();
    test_reset_mid_store();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
